// File: rtl/tc_mult_arbiter.sv
// Round-robin share of one u16 x s17 multiplier among NREQ requesters; result 2 cycles after grant.
// Backpressure: res_ready low freezes S2, S1 may still fill, then req_ready drops until res_ready returns.
module tc_mult_arbiter #(
   parameter int NREQ = 4,
   parameter int A_W  = 16,
   parameter int B_W  = 17,
   parameter int P_W  = 31,
   parameter int ID_W = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*A_W-1:0]   req_a,
   input  logic [NREQ*B_W-1:0]   req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ID_W-1:0]       res_id,
   output logic [P_W-1:0]        res_p,
   output logic [15:0]           issue_cnt
);

   localparam int FULL_W = A_W + B_W;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
      logic [A_W-1:0]  a;
      logic [B_W-1:0]  b;
   } s1_t;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
      logic [P_W-1:0]  p;
   } s2_t;

   s1_t              s1_q, s1_d;
   s2_t              s2_q, s2_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [15:0]      issue_cnt_q, issue_cnt_d;

   logic              adv1, adv2;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_id;
   logic signed [FULL_W-1:0] prod;

   assign adv2 = !s2_q.vld || res_ready;
   assign adv1 = !s1_q.vld || adv2;

   // Scan from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   // Reset gating keeps req_ready low while ap_rst_n is held, even though adv1 is high then.
   always_comb begin
      req_ready = '0;
      if (adv1 && grant_vld && ap_rst_n)
         req_ready[grant_id] = 1'b1;
   end

   // Zero-extend A and sign-extend B to the full width so the low bits are exact.
   assign prod = $signed({{B_W{1'b0}}, s1_q.a}) * $signed({{A_W{s1_q.b[B_W-1]}}, s1_q.b});

   always_comb begin
      s1_d        = s1_q;
      s2_d        = s2_q;
      ptr_d       = ptr_q;
      issue_cnt_d = issue_cnt_q;

      if (adv1) begin
         s1_d.vld = grant_vld;
         if (grant_vld) begin
            s1_d.id = grant_id;
            s1_d.a  = req_a[grant_id*A_W +: A_W];
            s1_d.b  = req_b[grant_id*B_W +: B_W];
            ptr_d   = grant_id;
         end
      end

      if (adv2) begin
         s2_d.vld = s1_q.vld;
         s2_d.id  = s1_q.id;
         s2_d.p   = prod[P_W-1:0];
      end

      if (s2_q.vld && res_ready)
         issue_cnt_d = issue_cnt_q + 16'd1;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         ptr_q       <= ID_W'(NREQ - 1);
         issue_cnt_q <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         ptr_q       <= ptr_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign res_valid = s2_q.vld;
   assign res_id    = s2_q.id;
   assign res_p     = s2_q.p;
   assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_tc_mult_arbiter.sv
// Directed bench for tc_mult_arbiter: handshake, round-robin order, backpressure, truncation, reset, counter wrap.
module tb_tc_mult_arbiter;
   localparam int NREQ = 4;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*16-1:0] req_a;
   logic [NREQ*17-1:0] req_b;
   logic              res_valid;
   logic              res_ready;
   logic [1:0]        res_id;
   logic [30:0]       res_p;
   logic [15:0]       issue_cnt;

   int n_vec = 0;
   int n_err = 0;

   tc_mult_arbiter dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_p     (res_p),
      .issue_cnt (issue_cnt)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [16:0] b);
      req_a[i*16 +: 16] = a;
      req_b[i*17 +: 17] = b;
   endtask

   task automatic nxt();
      @(posedge ap_clk);
      #1;
   endtask

   // Hand-computed low-31-bit products for the operand table below.
   logic [31:0] exp_p [4];
   logic [3:0]  bp_rdy [5];

   initial begin
      int exp_cnt;
      int accepts;
      int n_del;
      bit done;

      exp_p[0] = 32'h0000_0006;   // 2 * 3
      exp_p[1] = 32'h7FFF_FFFB;   // 5 * -1
      exp_p[2] = 32'h0001_0000;   // 0xFFFF * -65536, truncated
      exp_p[3] = 32'h0000_0000;   // 0 * -1
      bp_rdy[0] = 4'b0001; bp_rdy[1] = 4'b0010;
      bp_rdy[2] = 4'b0000; bp_rdy[3] = 4'b0000; bp_rdy[4] = 4'b0000;

      req_a = '0; req_b = '0;
      set_op(0, 16'd2, 17'd3);
      set_op(1, 16'd5, 17'h1FFFF);
      set_op(2, 16'd1000, 17'h1FFFD);
      set_op(3, 16'd0, 17'h1FFFF);
      ap_rst_n = 1'b0;
      req_valid = 4'b1111;
      res_ready = 1'b1;

      // Reset state, with every requester asking.
      @(negedge ap_clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_res_valid", 32'(res_valid), 32'h0);
      chk("rst_res_p", 32'(res_p), 32'h0);
      chk("rst_res_id", 32'(res_id), 32'h0);
      chk("rst_issue_cnt", 32'(issue_cnt), 32'h0);

      // Single request from requester 2: 1000 * -3.
      nxt();
      ap_rst_n = 1'b1;
      req_valid = 4'b0100;
      @(negedge ap_clk);
      chk("single_ready", 32'(req_ready), 32'h4);
      nxt();
      req_valid = 4'b0000;
      @(negedge ap_clk);
      chk("single_lat1_valid", 32'(res_valid), 32'h0);
      nxt();
      @(negedge ap_clk);
      chk("single_valid", 32'(res_valid), 32'h1);
      chk("single_id", 32'(res_id), 32'h2);
      chk("single_p", 32'(res_p), 32'h7FFF_F448);
      nxt();
      @(negedge ap_clk);
      chk("single_cnt", 32'(issue_cnt), 32'h1);
      chk("single_drained", 32'(res_valid), 32'h0);

      // Fresh reset, then all four requesting continuously.
      ap_rst_n = 1'b0;
      #1;
      ap_rst_n = 1'b1;
      set_op(2, 16'hFFFF, 17'h10000);
      exp_cnt = 0;
      nxt();
      req_valid = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         @(negedge ap_clk);
         chk("rr_grant", 32'(req_ready), 32'(1 << (t % 4)));
         if (t >= 2) begin
            chk("rr_valid", 32'(res_valid), 32'h1);
            chk("rr_id", 32'(res_id), 32'((t - 2) % 4));
            chk("rr_p", 32'(res_p), exp_p[(t - 2) % 4]);
            exp_cnt++;
         end else begin
            chk("rr_fill_valid", 32'(res_valid), 32'h0);
         end
         nxt();
         req_valid = (t == 7) ? 4'b0000 : 4'b1111;
      end
      for (int t = 8; t < 10; t++) begin
         @(negedge ap_clk);
         chk("rr_tail_id", 32'(res_id), 32'((t - 2) % 4));
         chk("rr_tail_p", 32'(res_p), exp_p[(t - 2) % 4]);
         exp_cnt++;
         nxt();
      end
      @(negedge ap_clk);
      chk("rr_empty", 32'(res_valid), 32'h0);
      chk("rr_cnt", 32'(issue_cnt), 32'(exp_cnt));

      // Backpressure for 5 cycles under continuous requests.
      nxt();
      res_ready = 1'b0;
      req_valid = 4'b1111;
      accepts = 0;
      for (int b = 0; b < 5; b++) begin
         @(negedge ap_clk);
         accepts += $countones(req_ready);
         chk("bp_ready", 32'(req_ready), 32'(bp_rdy[b]));
         if (b >= 2) begin
            chk("bp_hold_valid", 32'(res_valid), 32'h1);
            chk("bp_hold_id", 32'(res_id), 32'h0);
            chk("bp_hold_p", 32'(res_p), exp_p[0]);
         end
         nxt();
      end
      chk("bp_accepts", 32'(accepts), 32'd2);
      res_ready = 1'b1;
      @(negedge ap_clk);
      chk("bp_release_grant", 32'(req_ready), 32'h4);
      chk("bp_release_id", 32'(res_id), 32'h0);
      exp_cnt++;
      nxt();
      req_valid = 4'b0000;
      for (int r = 1; r < 3; r++) begin
         @(negedge ap_clk);
         chk("bp_drain_id", 32'(res_id), 32'(r));
         chk("bp_drain_p", 32'(res_p), exp_p[r]);
         exp_cnt++;
         nxt();
      end
      @(negedge ap_clk);
      chk("bp_empty", 32'(res_valid), 32'h0);
      chk("bp_cnt", 32'(issue_cnt), 32'(exp_cnt));

      // Reset with both stages full.
      nxt();
      res_ready = 1'b0;
      req_valid = 4'b1111;
      nxt();
      nxt();
      @(negedge ap_clk);
      chk("full_valid", 32'(res_valid), 32'h1);
      chk("full_id", 32'(res_id), 32'h3);
      chk("full_ready", 32'(req_ready), 32'h0);
      #2;
      ap_rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(res_valid), 32'h0);
      chk("arst_cnt", 32'(issue_cnt), 32'h0);
      chk("arst_ready", 32'(req_ready), 32'h0);
      nxt();
      ap_rst_n = 1'b1;
      res_ready = 1'b1;
      #1;
      chk("arst_first_grant", 32'(req_ready), 32'h1);

      // Stream until 65537 results have been delivered.
      n_del = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
         @(negedge ap_clk);
         if (res_valid && res_ready) begin
            n_del++;
            if (n_del == 65537) begin
               chk("wrap_pre", 32'(issue_cnt), 32'h0);
               done = 1'b1;
            end
         end
         nxt();
      end
      if (done) begin
         @(negedge ap_clk);
         chk("wrap_cnt", 32'(issue_cnt), 32'h1);
      end else begin
         n_vec++;
         n_err++;
         $error("FAIL wrap_timeout: observed %0d deliveries expected 65537", n_del);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
